// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sine generator.
package dds_pkg;

    localparam int unsigned DDS_PHASE_W = 24;
    localparam int unsigned DDS_ADDR_W  = 10;
    localparam int unsigned DDS_DATA_W  = 12;

    localparam int unsigned AMP_W     = 9;
    localparam int unsigned AMP_SHIFT = 8;
    localparam logic [AMP_W-1:0] AMP_UNITY = AMP_W'(256);

    // Quadrant of the full-wave address (top two address bits)
    typedef enum logic [1:0] {
        Q0_RISE = 2'd0,
        Q1_FALL = 2'd1,
        Q2_NEG  = 2'd2,
        Q3_RISE = 2'd3
    } quadrant_e;

    function automatic logic [AMP_W-1:0] amp_sat(input logic [AMP_W-1:0] a);
        return (a > AMP_UNITY) ? AMP_UNITY : a;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table built at elaboration, sampled at half-step offsets
// so the full wave is exactly quadrant-symmetric. One-cycle registered read.
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int unsigned ADDR_W = DDS_ADDR_W,
    parameter int unsigned DATA_W = DDS_DATA_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [ADDR_W-3:0]        addr,
    output logic signed [DATA_W-1:0] data
);

    localparam int unsigned K_W   = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << K_W;
    localparam real         PI    = 3.14159265358979323846;
    localparam real         AMPL  = (2.0 ** (DATA_W - 1)) - 1.0;

    logic signed [DATA_W-1:0] w_lut [DEPTH];

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_lut
        localparam int VAL = $rtoi(AMPL * $sin(2.0 * PI * (real'(g) + 0.5)
                                   / (2.0 ** ADDR_W)) + 0.5);
        assign w_lut[g] = DATA_W'(VAL);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            data <= '0;
        end else begin
            data <= w_lut[addr];
        end
    end

endmodule

// File: rtl/dds_sine_gen.sv
// Direct digital synthesis sine generator: phase accumulator, quarter-wave
// lookup with quadrant folding, amplitude scaling; fixed 3-cycle latency.
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W = DDS_PHASE_W,
    parameter int unsigned ADDR_W  = DDS_ADDR_W,
    parameter int unsigned DATA_W  = DDS_DATA_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     en,
    input  logic [PHASE_W-1:0]       ftw_in,
    input  logic                     ftw_load,
    input  logic [PHASE_W-1:0]       phase_off,
    input  logic [AMP_W-1:0]         amp_scale,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     wrap
);

    localparam int unsigned K_W     = ADDR_W - 2;
    localparam int unsigned Q_DEPTH = 1 << K_W;
    localparam int unsigned PROD_W  = DATA_W + AMP_W + 1;

    logic [PHASE_W-1:0]       r_acc;
    logic [PHASE_W-1:0]       r_ftw;
    logic                     r_carry;
    logic [ADDR_W-1:0]        r_addr_s1;
    logic [AMP_W-1:0]         r_amp_s1, r_amp_s2, r_amp_s3;
    logic [K_W-1:0]           r_idx_s2;
    logic                     r_neg_s2, r_neg_s3;
    logic [2:0]               r_vld;
    logic [2:0]               r_wrp;

    logic [PHASE_W:0]         w_acc_sum;
    logic [PHASE_W-1:0]       w_phase;
    logic                     w_unused_phase;
    quadrant_e                w_quad;
    logic [K_W-1:0]           w_k;
    logic [K_W-1:0]           w_idx;
    logic                     w_neg;
    logic signed [DATA_W-1:0] w_lut;
    logic signed [DATA_W-1:0] w_s;
    logic signed [PROD_W-1:0] w_prod;

    assign w_acc_sum      = {1'b0, r_acc} + {1'b0, r_ftw};
    assign w_phase        = r_acc + phase_off;
    assign w_unused_phase = ^w_phase[PHASE_W-ADDR_W-1:0];

    // Fold the full-wave address onto the quarter table
    assign w_quad = quadrant_e'(r_addr_s1[ADDR_W-1 -: 2]);
    assign w_k    = r_addr_s1[K_W-1:0];
    assign w_neg  = (w_quad == Q2_NEG) || (w_quad == Q3_RISE);

    always_comb begin
        w_idx = w_k;
        if ((w_quad == Q1_FALL) || (w_quad == Q3_RISE)) begin
            w_idx = K_W'(Q_DEPTH - 1) - w_k;
        end
    end

    sine_quarter_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .Clk   (Clk),
        .Reset (Reset),
        .addr  (r_idx_s2),
        .data  (w_lut)
    );

    assign w_s    = r_neg_s3 ? -w_lut : w_lut;
    assign w_prod = $signed(PROD_W'(w_s)) * $signed(PROD_W'({1'b0, r_amp_s3}));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_acc      <= '0;
            r_ftw      <= '0;
            r_carry    <= 1'b0;
            r_addr_s1  <= '0;
            r_amp_s1   <= '0;
            r_amp_s2   <= '0;
            r_amp_s3   <= '0;
            r_idx_s2   <= '0;
            r_neg_s2   <= 1'b0;
            r_neg_s3   <= 1'b0;
            r_vld      <= '0;
            r_wrp      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            if (ftw_load) begin
                r_ftw <= ftw_in;
            end
            // Stage 1: launch a sample; a pending carry marks it as a wrap
            if (en) begin
                r_acc     <= w_acc_sum[PHASE_W-1:0];
                r_carry   <= w_acc_sum[PHASE_W];
                r_addr_s1 <= w_phase[PHASE_W-1 -: ADDR_W];
                r_amp_s1  <= amp_sat(amp_scale);
            end
            r_vld <= {r_vld[1:0], en};
            r_wrp <= {r_wrp[1:0], en & r_carry};

            r_idx_s2 <= w_idx;
            r_neg_s2 <= w_neg;
            r_amp_s2 <= r_amp_s1;

            r_neg_s3 <= r_neg_s2;
            r_amp_s3 <= r_amp_s2;

            data_valid <= r_vld[2];
            wrap       <= r_wrp[2];
            if (r_vld[2]) begin
                data_out <= DATA_W'(w_prod >>> AMP_SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_dds_sine_gen.sv
// Directed self-checking bench for dds_sine_gen at default parameters.
module tb_dds_sine_gen;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               en;
    logic [23:0]        ftw_in;
    logic               ftw_load;
    logic [23:0]        phase_off;
    logic [8:0]         amp_scale;
    logic signed [11:0] data_out;
    logic               data_valid;
    logic               wrap;

    int n_chk = 0;
    int n_err = 0;
    int pat [4] = '{6, 2047, -6, -2047};

    int          samp [2100];
    int          wpos [4];
    int          nwrap;
    int          bad;
    int          launches;
    int          last;
    logic [15:0] hist;

    dds_sine_gen #(
        .PHASE_W (24),
        .ADDR_W  (10),
        .DATA_W  (12)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .en         (en),
        .ftw_in     (ftw_in),
        .ftw_load   (ftw_load),
        .phase_off  (phase_off),
        .amp_scale  (amp_scale),
        .data_out   (data_out),
        .data_valid (data_valid),
        .wrap       (wrap)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic [23:0] f, input logic [8:0] a,
                           input logic [23:0] off);
        Reset    = 1'b1;
        en       = 1'b0;
        ftw_load = 1'b0;
        step();
        Reset    = 1'b0;
        ftw_in   = f;
        ftw_load = 1'b1;
        step();
        ftw_load  = 1'b0;
        amp_scale = a;
        phase_off = off;
    endtask

    // Continuous en; expects a 4-periodic sample pattern, wrap every wper samples
    task automatic stream4(input string tag, input int p0, input int p1,
                           input int p2, input int p3, input int n,
                           input int wper);
        int q [4];
        q  = '{p0, p1, p2, p3};
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_lat"}, data_valid, 0);
        end
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_vld"}, data_valid, 1);
            chk({tag, "_dat"}, data_out, q[i % 4]);
            chk({tag, "_wrap"}, wrap, ((wper != 0) && (i > 0) && (i % wper == 0)) ? 1 : 0);
        end
        en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        Reset     = 1'b1;
        en        = 1'b0;
        ftw_in    = '0;
        ftw_load  = 1'b0;
        phase_off = '0;
        amp_scale = 9'd256;
        step();
        step();
        chk("reset_dat", data_out, 0);
        chk("reset_vld", data_valid, 0);
        chk("reset_wrap", wrap, 0);

        // Quarter-rate tone at unity and scaled amplitudes
        restart(24'h400000, 9'd256, 24'h0);
        stream4("q256", 6, 2047, -6, -2047, 8, 4);
        restart(24'h400000, 9'd128, 24'h0);
        stream4("q128", 3, 1023, -3, -1024, 4, 4);
        restart(24'h400000, 9'd300, 24'h0);
        stream4("q300", 6, 2047, -6, -2047, 4, 4);

        // Zero tuning word holds the phase at the offset
        restart(24'h0, 9'd256, 24'h400000);
        stream4("ftw0", 2047, 2047, 2047, 2047, 4, 0);

        // en toggling: bubbles hold data_out, no sample skipped
        restart(24'h400000, 9'd256, 24'h0);
        launches = 0;
        last     = 0;
        hist     = '0;
        for (int c = 0; c < 14; c++) begin
            en   = ((c < 8) && (c % 2 == 0)) ? 1'b1 : 1'b0;
            hist = {hist[14:0], en};
            step();
            if (hist[3]) begin
                last = pat[launches % 4];
                launches++;
            end
            chk("tog_vld", data_valid, hist[3] ? 1 : 0);
            chk("tog_dat", data_out, last);
        end

        // Fine tuning word: 1024-sample period, wrap once per period
        restart(24'h004000, 9'd256, 24'h0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        nwrap = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) wpos[i] = -1;
        for (int i = 0; i < 2100; i++) begin
            step();
            samp[i] = data_out;
            if (data_valid !== 1'b1) bad++;
            if (wrap === 1'b1) begin
                if (nwrap < 4) wpos[nwrap] = i;
                nwrap++;
            end
        end
        en = 1'b0;
        chk("per_allvalid", bad, 0);
        chk("per_nwrap", nwrap, 2);
        chk("per_wrap0", wpos[0], 1024);
        chk("per_wrap1", wpos[1], 2048);
        chk("per_s0", samp[0], 6);
        chk("per_s128", samp[128], 1452);
        chk("per_s256", samp[256], 2047);
        chk("per_s512", samp[512], -6);
        bad = 0;
        for (int n = 0; n < 1024; n++) if (samp[n + 512] != -samp[n]) bad++;
        chk("per_mirror", bad, 0);
        bad = 0;
        for (int n = 0; n < 1024; n++) if (samp[n + 1024] != samp[n]) bad++;
        chk("per_repeat", bad, 0);

        // Tuning word and phase offset change mid-stream
        restart(24'h400000, 9'd256, 24'h0);
        en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 5) begin
                ftw_in    = 24'h800000;
                ftw_load  = 1'b1;
                phase_off = 24'h400000;
            end else begin
                ftw_load = 1'b0;
            end
            step();
            if (c >= 3) begin
                case (c - 3)
                    0, 4:    chk("chg_dat", data_out, 6);
                    1:       chk("chg_dat", data_out, 2047);
                    2, 5:    chk("chg_dat", data_out, -6);
                    3:       chk("chg_dat", data_out, -2047);
                    default: chk("chg_dat", data_out, ((c - 3) % 2 == 0) ? -2047 : 2047);
                endcase
            end
        end
        en        = 1'b0;
        ftw_load  = 1'b0;
        phase_off = '0;

        // Reset with samples in flight, then restart from phase 0
        restart(24'h400000, 9'd256, 24'h0);
        en = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("rst_pre_vld", data_valid, 1);
        chk("rst_pre_dat", data_out, 2047);
        Reset = 1'b1;
        step();
        chk("rst_vld", data_valid, 0);
        chk("rst_dat", data_out, 0);
        chk("rst_wrap", wrap, 0);
        Reset = 1'b0;
        en    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_flush_vld", data_valid, 0);
            chk("rst_flush_dat", data_out, 0);
        end
        ftw_in   = 24'h400000;
        ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        stream4("rst_re", 6, 2047, -6, -2047, 4, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dds_sine_gen.md
DDS_SINE_GEN -- requirements
Module: dds_sine_gen

Interface
REQ-001 Parameter PHASE_W, default 24, phase accumulator and tuning-word width.
REQ-002 Parameter ADDR_W, default 10, full-wave table address width; the quarter-wave table depth Q is 2^(ADDR_W-2).
REQ-003 Parameter DATA_W, default 12, signed output sample width; the peak amplitude A is 2^(DATA_W-1)-1.
REQ-004 Port Clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port Reset, input, 1, synchronous and active-high.
REQ-006 Port en, input, 1, advances the phase accumulator and launches one sample.
REQ-007 Port ftw_in, input, PHASE_W, frequency tuning word.
REQ-008 Port ftw_load, input, 1, captures ftw_in into the internal FTW register.
REQ-009 Port phase_off, input, PHASE_W, phase offset added to each sample's phase.
REQ-010 Port amp_scale, input, 9, unsigned amplitude; 256 is unity and values above 256 saturate to 256.
REQ-011 Port data_out, output, DATA_W, signed sample.
REQ-012 Port data_valid, output, 1, asserted when data_out carries a new sample.
REQ-013 Port wrap, output, 1, asserted with the first sample of each new accumulator cycle.

Function
REQ-014 On a cycle with en=1, stage 1 SHALL register phase_r = acc + phase_off (mod 2^PHASE_W) and update acc <= acc + ftw_reg.
- The first sample after reset uses acc=0.
REQ-015 Stage 2 SHALL take addr = phase_r[PHASE_W-1 -: ADDR_W], quadrant q = addr[ADDR_W-1:ADDR_W-2], and k = addr[ADDR_W-3:0], and SHALL perform the table lookup as follows:
- Quadrants 0 and 2 read lut[k].
- Quadrants 1 and 3 read lut[Q-1-k].
- The negate flag is set for quadrants 2 and 3.
REQ-016 The table SHALL hold lut[k] = round(A*sin(2*pi*(k+0.5)/2^ADDR_W)) for k = 0..Q-1, so that the wave is exactly quadrant-symmetric.
REQ-017 Stage 3 SHALL compute s = negate ? -lut : lut, then data_out = (s * amp) >>> 8, where amp = min(amp_scale, 256).
- The shift is an arithmetic right shift (floor).
- The multiply is performed at full width before truncation to DATA_W.
REQ-018 Latency SHALL be exactly 3 cycles: en=1 sampled at edge t gives data_valid=1 with that sample after edge t+3.
REQ-019 The valid token SHALL travel through a 3-stage shift register. The pipeline always advances, and en=0 injects a bubble.
REQ-020 data_out SHALL hold its last value whenever data_valid=0.
REQ-021 When en=0, acc SHALL hold its value.
REQ-022 wrap SHALL be the carry-out of the acc update in REQ-014, delayed 3 cycles in step with its sample.
- Because wrap marks the first sample after the carry, it SHALL be asserted on the sample launched on the cycle following the carry.
REQ-023 When ftw_load=1, ftw_reg SHALL be updated at that edge. The new value applies to the acc update of the next en cycle, never to the current one.
REQ-024 phase_off and amp_scale SHALL be sampled at stage 1 and carried down the pipeline with the sample, so a change affects only later samples.
REQ-025 ftw_reg=0 with en=1 SHALL produce a constant stream of valid samples at phase phase_off.

Reset
REQ-026 When Reset=1 at an edge, the block SHALL clear the following to 0:
- acc and ftw_reg;
- every pipeline register;
- the valid and wrap shift registers;
- data_out, data_valid and wrap.
REQ-027 Reset SHALL take priority over en and ftw_load on the same edge. Samples in flight are discarded, and no valid output appears for 3 cycles after the first en following Reset.

Structure
REQ-028 A shared package dds_pkg SHALL hold the default parameter constants, the quadrant enum (Q0_RISE, Q1_FALL, Q2_NEG, Q3_RISE) and the unity-amplitude constant (256).
REQ-029 The quarter-wave table SHALL be one sub-module, sine_quarter_rom, which computes its contents from ADDR_W and DATA_W at elaboration and has a 1-cycle registered read.

Verification (defaults: PHASE_W=24, ADDR_W=10, DATA_W=12, A=2047)
REQ-030 Reset, then ftw_load with ftw_in=2^22, amp_scale=256, phase_off=0, en=1 continuously -> data_out repeats 6, 2047, -6, -2047, with the first valid output 3 cycles after en.
REQ-031 With ftw_in=2^14 and en=1 continuously -> period of 1024 valid samples; wrap pulses exactly once per period, 1024 samples apart; data_out(n+512) = -data_out(n).
REQ-032 Settings as REQ-030 but amp_scale=128 -> 3, 1023, -3, -1024; amp_scale=300 -> same as 256.
REQ-033 Settings as REQ-030 with en toggling 1,0,1,0 -> data_valid follows the same pattern delayed 3 cycles; data_out holds during bubbles; the sequence is not skipped.
REQ-034 ftw_load with ftw_in=2^23 mid-stream, phase_off=2^22 -> samples before the change are unaffected; afterwards the output alternates 2047 and -2047.
REQ-035 Reset asserted mid-stream with samples in flight -> data_valid=0, data_out=0 on the following cycles; on restart the first sample is 6 (phase 0).
